// File: rtl/lsf_rbin_sender.sv
// Transmit side of the LSF r-bin histogram interface: turns MDT hits into left/right
// r-bin pairs and sequences one theta slice (clear, stream, drain, done).
module lsf_rbin_sender #(
    parameter int RBINS        = 128,
    parameter int RBIN_WIDTH   = 8,
    parameter int R_WIDTH      = 12,
    parameter int D_WIDTH      = 10,
    parameter int R_OFFSET     = 1024,
    parameter int BIN_SHIFT    = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_HITS     = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slice_start,
    input  logic                  hit_valid,
    output logic                  hit_ready,
    input  logic [R_WIDTH-1:0]    hit_r,
    input  logic [D_WIDTH-1:0]    hit_drift,
    input  logic                  hit_last,
    output logic [RBIN_WIDTH-1:0] r_bin_0,
    output logic [RBIN_WIDTH-1:0] r_bin_1,
    output logic                  r_bin_vld,
    output logic                  enable_V,
    output logic                  reset_rbins,
    output logic                  slice_done,
    output logic [3:0]            hit_count,
    output logic                  overflow,
    output logic                  start_err,
    output logic                  busy
);

    localparam int XW = R_WIDTH + 2;
    localparam int SW = XW + 1;
    localparam logic signed [SW-1:0]   OFFS      = SW'(R_OFFSET);
    localparam logic signed [SW-1:0]   NBINS     = SW'(RBINS);
    localparam logic [RBIN_WIDTH-1:0]  BIN_INV   = {1'b1, {(RBIN_WIDTH-1){1'b0}}};
    localparam logic [3:0]             CAP       = 4'(MAX_HITS);
    localparam logic [7:0]             DRAIN_END = 8'(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              drain_q, drain_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic                    s1_vld_q, s1_vld_d;
    logic signed [XW-1:0]    lo_q, lo_d, hi_q, hi_d;
    logic [RBIN_WIDTH-1:0]   bin0_q, bin0_d, bin1_q, bin1_d;
    logic                    vld_q, vld_d;
    logic                    start_err_q, start_err_d;
    logic                    hit_ready_q, hit_ready_d;
    logic                    enable_q, enable_d;
    logic                    clear_q, clear_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic                    accept;
    logic signed [XW-1:0]    r_ext, d_ext;
    logic [RBIN_WIDTH-1:0]   b0, b1;

    function automatic logic [RBIN_WIDTH-1:0] to_bin(input logic signed [XW-1:0] x);
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] b;
        s = $signed({x[XW-1], x}) + OFFS;
        b = s >>> BIN_SHIFT;
        if (b >= 0 && b < NBINS) begin
            to_bin = {1'b0, b[RBIN_WIDTH-2:0]};
        end else begin
            to_bin = BIN_INV;
        end
    endfunction

    assign accept = hit_valid & hit_ready_q;
    assign r_ext  = {{2{hit_r[R_WIDTH-1]}}, hit_r};
    assign d_ext  = {{(XW-D_WIDTH){1'b0}}, hit_drift};
    assign b0     = to_bin(lo_q);
    assign b1     = to_bin(hi_q);

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        s1_vld_d    = 1'b0;
        lo_d        = lo_q;
        hi_d        = hi_q;
        start_err_d = slice_start && (state_q != StIdle);

        case (state_q)
            StIdle: begin
                if (slice_start) begin
                    state_d = StClear;
                    cnt_d   = 4'd0;
                    ovf_d   = 1'b0;
                end
            end
            StClear:  state_d = StStream;
            StStream: begin
                if (accept && hit_last) begin
                    state_d = StDrain;
                    drain_d = 8'd0;
                end
            end
            StDrain: begin
                if (drain_q == DRAIN_END) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 8'd1;
                end
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // Hits past the cap are consumed silently so the 4-bit bin counters never wrap.
        if (accept) begin
            if (cnt_q == CAP) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d    = cnt_q + 4'd1;
                s1_vld_d = 1'b1;
                lo_d     = r_ext - d_ext;
                hi_d     = r_ext + d_ext;
            end
        end

        vld_d  = s1_vld_q;
        bin0_d = BIN_INV;
        bin1_d = BIN_INV;
        if (s1_vld_q) begin
            bin0_d = b0;
            // The accumulator adds once per index per cycle, so a coincident pair counts once.
            bin1_d = (!b0[RBIN_WIDTH-1] && (b0 == b1)) ? BIN_INV : b1;
        end

        hit_ready_d = (state_d == StStream);
        enable_d    = (state_d == StStream) || (state_d == StDrain) || (state_d == StDone);
        clear_d     = (state_d == StClear);
        done_d      = (state_d == StDone);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            drain_q     <= 8'd0;
            cnt_q       <= 4'd0;
            ovf_q       <= 1'b0;
            s1_vld_q    <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            bin0_q      <= BIN_INV;
            bin1_q      <= BIN_INV;
            vld_q       <= 1'b0;
            start_err_q <= 1'b0;
            hit_ready_q <= 1'b0;
            enable_q    <= 1'b0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            s1_vld_q    <= s1_vld_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            bin0_q      <= bin0_d;
            bin1_q      <= bin1_d;
            vld_q       <= vld_d;
            start_err_q <= start_err_d;
            hit_ready_q <= hit_ready_d;
            enable_q    <= enable_d;
            clear_q     <= clear_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign hit_ready   = hit_ready_q;
    assign r_bin_0     = bin0_q;
    assign r_bin_1     = bin1_q;
    assign r_bin_vld   = vld_q;
    assign enable_V    = enable_q;
    assign reset_rbins = clear_q;
    assign slice_done  = done_q;
    assign hit_count   = cnt_q;
    assign overflow    = ovf_q;
    assign start_err   = start_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lsf_rbin_sender.sv
// Directed bench for lsf_rbin_sender with a behavioural histogram accumulator model.
module tb_lsf_rbin_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        slice_start = 1'b0;
    logic        hit_valid = 1'b0;
    logic        hit_ready;
    logic [11:0] hit_r = '0;
    logic [9:0]  hit_drift = '0;
    logic        hit_last = 1'b0;
    logic [7:0]  r_bin_0, r_bin_1;
    logic        r_bin_vld, enable_V, reset_rbins, slice_done;
    logic [3:0]  hit_count;
    logic        overflow, start_err, busy;

    int total = 0;
    int bad   = 0;

    int tot_vld = 0;
    int tot_dup_nz = 0;
    int run = 0;
    int last_run = 0;
    logic [3:0] acc [128];

    lsf_rbin_sender dut (
        .clk         (clk),
        .rst         (rst),
        .slice_start (slice_start),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_r       (hit_r),
        .hit_drift   (hit_drift),
        .hit_last    (hit_last),
        .r_bin_0     (r_bin_0),
        .r_bin_1     (r_bin_1),
        .r_bin_vld   (r_bin_vld),
        .enable_V    (enable_V),
        .reset_rbins (reset_rbins),
        .slice_done  (slice_done),
        .hit_count   (hit_count),
        .overflow    (overflow),
        .start_err   (start_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Output monitor and accumulator model, sampled mid-cycle.
    always @(negedge clk) begin
        if (r_bin_vld) begin
            tot_vld = tot_vld + 1;
            run = run + 1;
            if (r_bin_1 !== 8'h80) tot_dup_nz = tot_dup_nz + 1;
        end else begin
            if (run != 0) last_run = run;
            run = 0;
        end
        if (reset_rbins) begin
            for (int i = 0; i < 128; i++) acc[i] = 4'd0;
        end else if (enable_V && r_bin_vld) begin
            if (!r_bin_0[7]) acc[r_bin_0[6:0]] = acc[r_bin_0[6:0]] + 4'd1;
            if (!r_bin_1[7]) acc[r_bin_1[6:0]] = acc[r_bin_1[6:0]] + 4'd1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_hit(input logic [11:0] r, input logic [9:0] d, input logic last);
        hit_valid = 1'b1;
        hit_r     = r;
        hit_drift = d;
        hit_last  = last;
    endtask

    task automatic idle_hit;
        hit_valid = 1'b0;
        hit_last  = 1'b0;
    endtask

    task automatic start_slice;
        slice_start = 1'b1;
        tick;
        total++;
        if (reset_rbins !== 1'b1 || busy !== 1'b1 || enable_V !== 1'b0 || hit_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_c1: got clr=%b busy=%b en=%b rdy=%b exp 1 1 0 0",
                     reset_rbins, busy, enable_V, hit_ready);
        end
        slice_start = 1'b0;
        tick;
        total++;
        if (enable_V !== 1'b1 || hit_ready !== 1'b1 || reset_rbins !== 1'b0) begin
            bad++;
            $display("FAIL start_c2: got en=%b rdy=%b clr=%b exp 1 1 0",
                     enable_V, hit_ready, reset_rbins);
        end
    endtask

    // Wait (bounded) for slice_done, check its latency, then check the return to IDLE.
    task automatic finish_slice(input string name, input int exp_ticks);
        int n = 0;
        while (slice_done !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        total++;
        if (slice_done !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_timeout: got slice_done=%b after %0d cycles exp 1", name,
                     slice_done, n);
        end else if (n != exp_ticks) begin
            bad++;
            $display("FAIL %s_done_latency: got %0d cycles exp %0d", name, n, exp_ticks);
        end
        tick;
        total++;
        if (busy !== 1'b0 || enable_V !== 1'b0 || slice_done !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: got busy=%b en=%b done=%b exp 0 0 0", name, busy, enable_V,
                     slice_done);
        end
    endtask

    task automatic test_reset;
        tick;
        tick;
        total++;
        if (r_bin_0 !== 8'h80 || r_bin_1 !== 8'h80 || r_bin_vld !== 1'b0 || enable_V !== 1'b0 ||
            reset_rbins !== 1'b0 || hit_ready !== 1'b0 || slice_done !== 1'b0 ||
            start_err !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || hit_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_vals: got b0=%h b1=%h vld=%b en=%b clr=%b rdy=%b done=%b err=%b busy=%b ovf=%b cnt=%0d exp 80 80 and zeros",
                     r_bin_0, r_bin_1, r_bin_vld, enable_V, reset_rbins, hit_ready, slice_done,
                     start_err, busy, overflow, hit_count);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single;
        start_slice;
        set_hit(12'd0, 10'd32, 1'b0);
        tick;
        total++;
        if (hit_count !== 4'd1) begin
            bad++;
            $display("FAIL single_cnt1: got %0d exp 1", hit_count);
        end
        set_hit(12'd160, 10'd0, 1'b1);
        tick;
        idle_hit;
        total++;
        if (r_bin_vld !== 1'b1 || r_bin_0 !== 8'h3E || r_bin_1 !== 8'h42 || hit_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_pair1: got vld=%b %h/%h rdy=%b exp 1 3e/42 0", r_bin_vld,
                     r_bin_0, r_bin_1, hit_ready);
        end
        tick;
        total++;
        if (r_bin_vld !== 1'b1 || r_bin_0 !== 8'h4A || r_bin_1 !== 8'h80 || hit_count !== 4'd2) begin
            bad++;
            $display("FAIL single_pair2: got vld=%b %h/%h cnt=%0d exp 1 4a/80 2", r_bin_vld,
                     r_bin_0, r_bin_1, hit_count);
        end
        finish_slice("single", 4);
    endtask

    task automatic test_range;
        start_slice;
        set_hit(-12'sd1024, 10'd0, 1'b0);
        tick;
        set_hit(12'd1023, 10'd0, 1'b0);
        tick;
        total++;
        if (r_bin_vld !== 1'b1 || r_bin_0 !== 8'h00 || r_bin_1 !== 8'h80) begin
            bad++;
            $display("FAIL range_lo: got vld=%b %h/%h exp 1 00/80", r_bin_vld, r_bin_0, r_bin_1);
        end
        set_hit(-12'sd1024, 10'd16, 1'b1);
        tick;
        idle_hit;
        total++;
        if (r_bin_vld !== 1'b1 || r_bin_0 !== 8'h7F || r_bin_1 !== 8'h80) begin
            bad++;
            $display("FAIL range_hi: got vld=%b %h/%h exp 1 7f/80", r_bin_vld, r_bin_0, r_bin_1);
        end
        tick;
        total++;
        if (r_bin_vld !== 1'b1 || r_bin_0 !== 8'h80 || r_bin_1 !== 8'h01) begin
            bad++;
            $display("FAIL range_under: got vld=%b %h/%h exp 1 80/01", r_bin_vld, r_bin_0,
                     r_bin_1);
        end
        tick;
        total++;
        if (r_bin_vld !== 1'b0 || r_bin_0 !== 8'h80 || r_bin_1 !== 8'h80) begin
            bad++;
            $display("FAIL range_hold: got vld=%b %h/%h exp 0 80/80", r_bin_vld, r_bin_0,
                     r_bin_1);
        end
        finish_slice("range", 3);
    endtask

    task automatic test_cap;
        int v0 = tot_vld;
        int d0 = tot_dup_nz;
        start_slice;
        for (int i = 0; i < 17; i++) begin
            set_hit(12'd0, 10'd0, (i == 16));
            tick;
            total++;
            if (hit_count !== 4'((i + 1 > 15) ? 15 : i + 1) || overflow !== (i >= 15)) begin
                bad++;
                $display("FAIL cap_hit%0d: got cnt=%0d ovf=%b exp %0d %b", i + 1, hit_count,
                         overflow, (i + 1 > 15) ? 15 : i + 1, (i >= 15));
            end
        end
        idle_hit;
        finish_slice("cap", 5);
        total++;
        if (tot_vld - v0 != 15 || tot_dup_nz != d0 || hit_count !== 4'd15 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL cap_summary: got emits=%0d dup_nz=%0d cnt=%0d ovf=%b exp 15 0 15 1",
                     tot_vld - v0, tot_dup_nz - d0, hit_count, overflow);
        end
    endtask

    task automatic test_back_to_back;
        int v0 = tot_vld;
        start_slice;
        total++;
        if (overflow !== 1'b0 || hit_count !== 4'd0) begin
            bad++;
            $display("FAIL b2b_clear: got ovf=%b cnt=%0d exp 0 0", overflow, hit_count);
        end
        for (int i = 0; i < 8; i++) begin
            set_hit(12'(i * 16), 10'd0, (i == 7));
            tick;
        end
        idle_hit;
        slice_start = 1'b1;
        tick;
        slice_start = 1'b0;
        total++;
        if (start_err !== 1'b1 || busy !== 1'b1 || reset_rbins !== 1'b0) begin
            bad++;
            $display("FAIL b2b_start_err: got err=%b busy=%b clr=%b exp 1 1 0", start_err, busy,
                     reset_rbins);
        end
        tick;
        total++;
        if (start_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_err_pulse: got err=%b exp 0", start_err);
        end
        finish_slice("b2b", 3);
        total++;
        if (tot_vld - v0 != 8 || last_run != 8) begin
            bad++;
            $display("FAIL b2b_run: got emits=%0d run=%0d exp 8 8", tot_vld - v0, last_run);
        end
    endtask

    task automatic test_reset_mid;
        int v0;
        start_slice;
        set_hit(12'd0, 10'd0, 1'b0);
        tick;
        set_hit(12'd16, 10'd0, 1'b0);
        tick;
        set_hit(12'd32, 10'd0, 1'b0);
        tick;
        idle_hit;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (r_bin_0 !== 8'h80 || r_bin_1 !== 8'h80 || r_bin_vld !== 1'b0 || enable_V !== 1'b0 ||
            reset_rbins !== 1'b0 || hit_ready !== 1'b0 || slice_done !== 1'b0 ||
            start_err !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || hit_count !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_vals: got b0=%h b1=%h vld=%b en=%b clr=%b rdy=%b busy=%b cnt=%0d exp reset values",
                     r_bin_0, r_bin_1, r_bin_vld, enable_V, reset_rbins, hit_ready, busy,
                     hit_count);
        end
        v0 = tot_vld;
        tick;
        tick;
        tick;
        total++;
        if (tot_vld != v0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_discard: got extra_vld=%0d busy=%b exp 0 0", tot_vld - v0, busy);
        end
        start_slice;
        set_hit(12'd160, 10'd0, 1'b1);
        tick;
        idle_hit;
        tick;
        total++;
        if (r_bin_vld !== 1'b1 || r_bin_0 !== 8'h4A || r_bin_1 !== 8'h80 || hit_count !== 4'd1) begin
            bad++;
            $display("FAIL rstmid_new: got vld=%b %h/%h cnt=%0d exp 1 4a/80 1", r_bin_vld,
                     r_bin_0, r_bin_1, hit_count);
        end
        finish_slice("rstmid", 4);
    endtask

    task automatic test_loopback;
        int best_idx = 0;
        int best_cnt = 0;
        start_slice;
        set_hit(12'd100, 10'd0, 1'b0);
        tick;
        set_hit(12'd96, 10'd0, 1'b0);
        tick;
        set_hit(12'd104, 10'd8, 1'b1);
        tick;
        idle_hit;
        finish_slice("loop", 5);
        for (int i = 0; i < 128; i++) begin
            if (int'(acc[i]) > best_cnt) begin
                best_cnt = int'(acc[i]);
                best_idx = i;
            end
        end
        total++;
        if (best_idx != 70 || best_cnt != 3 || acc[71] !== 4'd1) begin
            bad++;
            $display("FAIL loop_max: got bin=%0d count=%0d bin71=%0d exp 70 3 1", best_idx,
                     best_cnt, acc[71]);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_range;
        test_cap;
        test_back_to_back;
        test_reset_mid;
        test_loopback;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
